// File: rtl/mux_14.sv
// Registered 4:1 multiplexer with a combinational look-ahead output.
// y follows y_comb one clock later; a synchronous active-high rst loads RESET_VAL.
module mux_14 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0,
    input  logic             s1,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y_comb,
    output logic [WIDTH-1:0] y
);

    logic [1:0]       sel_s;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    assign sel_s = {s1, s0};

    // Word-wide input selection; an unknown select propagates X in simulation.
    always_comb begin
        y_d = {WIDTH{1'b0}};
        case (sel_s)
            2'b00:   y_d = i0;
            2'b01:   y_d = i1;
            2'b10:   y_d = i2;
            2'b11:   y_d = i3;
            default: y_d = {WIDTH{1'bx}};
        endcase
    end

    // Output register; rst has priority over the selected data.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= RESET_VAL;
        end else begin
            y_q <= y_d;
        end
    end

    assign y_comb = y_d;
    assign y      = y_q;

endmodule

// File: tb/tb_mux_14.sv
// Directed bench for mux_14: a 1-bit instance with default reset value and an
// 8-bit instance with a non-zero reset value, sharing clock, reset and select.
module tb_mux_14;

    logic       clk;
    logic       rst;
    logic       s0;
    logic       s1;
    logic       a0, a1, a2, a3;
    logic       ya_comb, ya;
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] yb_comb, yb;

    int errors;
    int checks;

    localparam logic [7:0] RV8 = 8'h81;

    mux_14 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .s0(s0), .s1(s1),
        .i0(a0), .i1(a1), .i2(a2), .i3(a3),
        .y_comb(ya_comb), .y(ya)
    );

    mux_14 #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
        .clk(clk), .rst(rst), .s0(s0), .s1(s1),
        .i0(b0), .i1(b1), .i2(b2), .i3(b3),
        .y_comb(yb_comb), .y(yb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] sel;
        logic [7:0] comb8;
        logic [7:0] y8;
        logic       comb1;
        logic       y1;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        {s1, s0} = 2'b00;
        {a0, a1, a2, a3} = 4'b1001;
        b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hFF; b3 = 8'h00;

        //            rst   sel    comb8  y8     comb1 y1
        vecs[0] = '{1'b1, 2'b00, 8'hA5, RV8,   1'b1, 1'b0};
        vecs[1] = '{1'b1, 2'b11, 8'h00, RV8,   1'b1, 1'b0};
        vecs[2] = '{1'b0, 2'b00, 8'hA5, 8'hA5, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 2'b10, 8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 2'b11, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 2'b01, 8'h3C, 8'h3C, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 2'b11, 8'h00, RV8,   1'b1, 1'b0};
        vecs[7] = '{1'b0, 2'b11, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 2'b10, 8'hFF, 8'hFF, 1'b0, 1'b0};

        for (int k = 0; k < 9; k++) begin
            rst = vecs[k].rst;
            {s1, s0} = vecs[k].sel;
            #1;
            chk($sformatf("v%0d comb8", k), yb_comb, vecs[k].comb8);
            chk($sformatf("v%0d comb1", k), {7'd0, ya_comb}, {7'd0, vecs[k].comb1});
            tick();
            chk($sformatf("v%0d y8", k), yb, vecs[k].y8);
            chk($sformatf("v%0d y1", k), {7'd0, ya}, {7'd0, vecs[k].y1});
        end

        // Latency: select changes just after an edge reach y only at the next edge.
        {s1, s0} = 2'b00;
        tick();
        chk("lat y8 pre", yb, 8'hA5);
        {s1, s0} = 2'b11;
        #1;
        chk("lat comb8", yb_comb, 8'h00);
        chk("lat y8 hold", yb, 8'hA5);
        tick();
        chk("lat y8 post", yb, 8'h00);

        // Data change with select held; unselected inputs have no effect.
        {s1, s0} = 2'b01;
        tick();
        chk("dat y8 pre", yb, 8'h3C);
        chk("dat y1 pre", {7'd0, ya}, 8'h00);
        b1 = 8'hC3;
        a1 = 1'b1;
        #1;
        chk("dat comb8", yb_comb, 8'hC3);
        chk("dat comb1", {7'd0, ya_comb}, 8'h01);
        chk("dat y8 hold", yb, 8'h3C);
        chk("dat y1 hold", {7'd0, ya}, 8'h00);
        b0 = 8'h00; b2 = 8'h00; b3 = 8'hFF;
        a0 = 1'b0; a2 = 1'b1; a3 = 1'b0;
        #1;
        chk("oth comb8", yb_comb, 8'hC3);
        chk("oth comb1", {7'd0, ya_comb}, 8'h01);
        chk("oth y8 hold", yb, 8'h3C);
        tick();
        chk("dat y8 post", yb, 8'hC3);
        chk("dat y1 post", {7'd0, ya}, 8'h01);

        // Select and data change together: the new input's new value is loaded.
        {s1, s0} = 2'b10;
        b2 = 8'h42;
        a2 = 1'b0;
        tick();
        chk("both y8", yb, 8'h42);
        chk("both y1", {7'd0, ya}, 8'h00);

        // Reset asserted mid-cycle acts only at the edge; y_comb stays live.
        rst = 1'b1;
        #1;
        chk("rst sync y8", yb, 8'h42);
        chk("rst comb8", yb_comb, 8'h42);
        tick();
        chk("rst y8", yb, RV8);
        chk("rst y1", {7'd0, ya}, 8'h00);
        rst = 1'b0;
        {s1, s0} = 2'b11;
        tick();
        chk("rel y8", yb, 8'hFF);
        chk("rel y1", {7'd0, ya}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
